pipelined_addsub: RTL

- Parametrised, pipelined successor to the team's fixed-width ripple-carry adder.
- Adds or subtracts two N-bit operands. The carry chain is split into STAGES equal segments, with a register after each segment.
- Sustains one operation per clock with a valid/ready handshake on both sides.
- Sits between operand sources (register file / DMA) and result consumers in datapath blocks that need adders wider than one cycle's ripple budget allows.

---
 rtl/pipelined_addsub.sv | 105 ++++++++++
 1 files changed

// File: rtl/pipelined_addsub.sv
// Pipelined N-bit adder/subtractor: the carry chain is cut into STAGES equal
// segments, each followed by a register, with a whole-pipe valid/ready stall.
module pipelined_addsub #(
   parameter int N      = 32,
   parameter int STAGES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         ovf
);

   localparam int W = N / STAGES;
   localparam int L = STAGES - 1;

   if (N < 2 || STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_param_check
      $error("pipelined_addsub: N must be >= 2 and a multiple of STAGES, 1 <= STAGES <= N");
   end

   // Handshake: a beat moves on a rising edge when valid && ready on that side.
   // The whole pipe shifts together whenever the output slot is empty or drained.
   logic advance;

   // Stage registers: skewed operands, de-skewed partial sums, carry and valid.
   logic [N-1:0] ra [STAGES];
   logic [N-1:0] rb [STAGES];
   logic [N-1:0] rs [STAGES];
   logic         rc [STAGES];
   logic         rv [STAGES];
   logic         rovf;

   // Values presented to each segment and the values it produces.
   logic [N-1:0] pa  [STAGES];
   logic [N-1:0] pb  [STAGES];
   logic [N-1:0] ps  [STAGES];
   logic         pc  [STAGES];
   logic         pv  [STAGES];
   logic [N-1:0] ns  [STAGES];
   logic         nc  [STAGES];
   logic [W:0]   seg [STAGES];
   logic         novf;

   assign advance = !rv[L] || out_ready;

   always_comb begin
      pa[0] = a;
      pb[0] = sub ? ~b : b;
      ps[0] = '0;
      pc[0] = sub | cin;
      pv[0] = in_valid;
      for (int k = 1; k < STAGES; k++) begin
         pa[k] = ra[k-1];
         pb[k] = rb[k-1];
         ps[k] = rs[k-1];
         pc[k] = rc[k-1];
         pv[k] = rv[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         seg[k] = {1'b0, pa[k][k*W +: W]} + {1'b0, pb[k][k*W +: W]} + {{W{1'b0}}, pc[k]};
         ns[k]  = ps[k];
         ns[k][k*W +: W] = seg[k][W-1:0];
         nc[k]  = seg[k][W];
      end
      // Carry into the MSB is recovered from the MSB sum bit and its operands.
      novf = nc[L] ^ pa[L][N-1] ^ pb[L][N-1] ^ ns[L][N-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            ra[k] <= '0;
            rb[k] <= '0;
            rs[k] <= '0;
            rc[k] <= 1'b0;
            rv[k] <= 1'b0;
         end
         rovf <= 1'b0;
      end else if (advance) begin
         for (int k = 0; k < STAGES; k++) begin
            ra[k] <= pa[k];
            rb[k] <= pb[k];
            rs[k] <= ns[k];
            rc[k] <= nc[k];
            rv[k] <= pv[k];
         end
         rovf <= novf;
      end
   end

   assign in_ready  = advance;
   assign out_valid = rv[L];
   assign sum       = rs[L];
   assign cout      = rc[L];
   assign ovf       = rovf;

endmodule
